// File: rtl/ysyx_24080014_pkg.sv
// rtl/ysyx_24080014_pkg.sv - shared funct3 encodings and LSU state type
package ysyx_24080014_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/ysyx_24080014_lsu_align.sv
// rtl/ysyx_24080014_lsu_align.sv - store lane/mask, legality and load extend logic
module ysyx_24080014_lsu_align
    import ysyx_24080014_pkg::*;
(
    input  logic        req_wen,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_offset,
    input  logic [31:0] req_wdata,
    output logic        legal,
    output logic [31:0] lane_wdata,
    output logic [3:0]  lane_wmask,
    input  logic [2:0]  rsp_funct3,
    input  logic [1:0]  rsp_offset,
    input  logic [31:0] rsp_rdata,
    output logic [31:0] load_ext
);

    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;

    always_comb begin
        legal      = 1'b0;
        lane_wdata = req_wdata;
        lane_wmask = 4'b0000;
        case (req_funct3)
            F3_B: begin
                legal      = 1'b1;
                lane_wdata = {4{req_wdata[7:0]}};
                lane_wmask = 4'b0001 << req_offset;
            end
            F3_H: begin
                legal      = !req_offset[0];
                lane_wdata = {2{req_wdata[15:0]}};
                lane_wmask = req_offset[1] ? 4'b1100 : 4'b0011;
            end
            F3_W: begin
                legal      = (req_offset == 2'b00);
                lane_wmask = 4'b1111;
            end
            // Unsigned variants exist only for loads
            F3_BU:   legal = !req_wen;
            F3_HU:   legal = !req_wen && !req_offset[0];
            default: legal = 1'b0;
        endcase
        if (!req_wen) begin
            lane_wmask = 4'b0000;
        end
    end

    always_comb begin
        rsp_byte = rsp_rdata[7:0];
        case (rsp_offset)
            2'd0:    rsp_byte = rsp_rdata[7:0];
            2'd1:    rsp_byte = rsp_rdata[15:8];
            2'd2:    rsp_byte = rsp_rdata[23:16];
            default: rsp_byte = rsp_rdata[31:24];
        endcase
        rsp_half = rsp_offset[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
    end

    always_comb begin
        load_ext = rsp_rdata;
        case (rsp_funct3)
            F3_B:    load_ext = {{24{rsp_byte[7]}}, rsp_byte};
            F3_H:    load_ext = {{16{rsp_half[15]}}, rsp_half};
            F3_W:    load_ext = rsp_rdata;
            F3_BU:   load_ext = {24'd0, rsp_byte};
            F3_HU:   load_ext = {16'd0, rsp_half};
            default: load_ext = rsp_rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_24080014_lsu.sv
// rtl/ysyx_24080014_lsu.sv - single-outstanding load/store unit with registered completion
module ysyx_24080014_lsu
    import ysyx_24080014_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic [31:0] load_data,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_wen,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_wmask,
    input  logic        bus_rsp_valid,
    output logic        bus_rsp_ready,
    input  logic [31:0] bus_rsp_rdata,
    input  logic        bus_rsp_err
);

    lsu_state_t  state_q, state_d;
    logic        wen_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic        mem_ready_q;
    logic        mem_err_q;
    logic [31:0] load_data_q;

    logic        legal;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wmask;
    logic [31:0] load_ext;
    logic        req_fire;
    logic        rsp_fire;

    ysyx_24080014_lsu_align u_align (
        .req_wen    (req_wen),
        .req_funct3 (req_funct3),
        .req_offset (req_addr[1:0]),
        .req_wdata  (req_wdata),
        .legal      (legal),
        .lane_wdata (lane_wdata),
        .lane_wmask (lane_wmask),
        .rsp_funct3 (funct3_q),
        .rsp_offset (offset_q),
        .rsp_rdata  (bus_rsp_rdata),
        .load_ext   (load_ext)
    );

    assign req_fire = req_valid && req_ready;
    assign rsp_fire = bus_rsp_valid && bus_rsp_ready;

    // Handshake outputs decode straight from state so reset drops them asynchronously
    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        bus_req_valid = 1'b0;
        bus_rsp_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && legal) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                bus_req_valid = 1'b1;
                if (bus_req_ready) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                bus_rsp_ready = 1'b1;
                if (bus_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wen_q       <= 1'b0;
            funct3_q    <= 3'b000;
            offset_q    <= 2'b00;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wmask_q     <= 4'b0000;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            load_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            if (req_fire) begin
                wen_q    <= req_wen;
                funct3_q <= req_funct3;
                offset_q <= req_addr[1:0];
                addr_q   <= {req_addr[31:2], 2'b00};
                wdata_q  <= lane_wdata;
                wmask_q  <= lane_wmask;
                // Illegal ops complete next cycle without touching the bus
                if (!legal) begin
                    mem_ready_q <= 1'b1;
                    mem_err_q   <= 1'b1;
                    if (!req_wen) begin
                        load_data_q <= 32'd0;
                    end
                end
            end
            if (rsp_fire) begin
                mem_ready_q <= 1'b1;
                mem_err_q   <= bus_rsp_err;
                if (!wen_q) begin
                    load_data_q <= bus_rsp_err ? 32'd0 : load_ext;
                end
            end
        end
    end

    assign mem_ready     = mem_ready_q;
    assign mem_err       = mem_err_q;
    assign load_data     = load_data_q;
    assign bus_req_wen   = wen_q;
    assign bus_req_addr  = addr_q;
    assign bus_req_wdata = wdata_q;
    assign bus_req_wmask = wmask_q;

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// tb/tb_ysyx_24080014_lsu.sv - self-checking bench for ysyx_24080014_lsu
module tb_ysyx_24080014_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        mem_ready;
    logic        mem_err;
    logic [31:0] load_data;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic        bus_req_wen;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_wmask;
    logic        bus_rsp_valid = 1'b0;
    logic        bus_rsp_ready;
    logic [31:0] bus_rsp_rdata = 32'd0;
    logic        bus_rsp_err = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_load = 32'd0;

    typedef struct {
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          rqw;
        int          rsw;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_baddr;
        logic [31:0] exp_bwdata;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_load;
    } vec_t;

    vec_t tbl [15];

    ysyx_24080014_lsu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wen       (req_wen),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .mem_ready     (mem_ready),
        .mem_err       (mem_err),
        .load_data     (load_data),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_wen   (bus_req_wen),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wdata (bus_req_wdata),
        .bus_req_wmask (bus_req_wmask),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_ready (bus_rsp_ready),
        .bus_rsp_rdata (bus_rsp_rdata),
        .bus_rsp_err   (bus_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: derives expectations from access size, signedness and byte offset
    function automatic vec_t add_expect(input vec_t v);
        vec_t        r;
        int          size;
        int          off;
        int          nbytes;
        bit          uns;
        bit          legal;
        logic [63:0] bits;
        logic [63:0] val;
        logic [31:0] rep;
        r      = v;
        size   = int'(v.f3[1:0]);
        uns    = v.f3[2];
        off    = int'(v.addr % 4);
        legal  = (size != 3) && !(uns && (v.wen || size == 2));
        if (legal) legal = (off % (1 << size)) == 0;
        nbytes = (size == 3) ? 4 : (1 << size);
        bits   = (64'd1 << (8 * nbytes)) - 64'd1;
        r.exp_baddr  = v.addr - 32'(off);
        r.exp_wmask  = 4'd0;
        r.exp_bwdata = 32'd0;
        if (v.wen && legal) begin
            rep = (nbytes == 1) ? 32'h0101_0101 : (nbytes == 2) ? 32'h0001_0001 : 32'd1;
            r.exp_bwdata = 32'((64'(v.wdata) & bits) * 64'(rep));
            r.exp_wmask  = 4'(((1 << nbytes) - 1) << off);
        end
        r.exp_err = !legal || v.err;
        r.exp_lat = legal ? 3 + v.rqw + v.rsw : 1;
        if (!v.wen) begin
            val = (64'(v.rdata) >> (8 * off)) & bits;
            if (!uns && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~bits;
            model_load = r.exp_err ? 32'd0 : val[31:0];
        end
        r.exp_load = model_load;
        return r;
    endfunction

    // Issues one op starting in the current cycle and plays the bus slave until mem_ready
    task automatic do_op(input vec_t v, output int lat, output logic err_o, output logic [31:0] ld_o,
                         output bit bus_seen, output logic [31:0] baddr, output logic [31:0] bwdata,
                         output logic [3:0] bmask, output logic bwen, output bit stable,
                         output bit busy_ok, output bit rr_ok);
        int rq;
        int rs;
        bit done;
        rr_ok = (req_ready === 1'b1);
        req_valid = 1'b1; req_wen = v.wen; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        rq = v.rqw; rs = v.rsw; lat = -1; err_o = 1'b0; ld_o = 32'd0;
        bus_seen = 0; stable = 1; busy_ok = 1; done = 0;
        baddr = 32'd0; bwdata = 32'd0; bmask = 4'd0; bwen = 1'b0;
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = $urandom;
            bus_req_ready = 1'($urandom_range(0, 1));
            bus_rsp_valid = 1'($urandom_range(0, 1));
            bus_rsp_rdata = $urandom;
            bus_rsp_err   = 1'($urandom_range(0, 1));
            if (mem_ready === 1'b1) begin
                lat = c; err_o = mem_err; ld_o = load_data; done = 1;
            end else if (req_ready !== 1'b0) begin
                busy_ok = 0;
            end
            if (bus_req_valid === 1'b1) begin
                if (!bus_seen) begin
                    baddr = bus_req_addr; bwdata = bus_req_wdata; bmask = bus_req_wmask; bwen = bus_req_wen;
                end else if (baddr !== bus_req_addr || bwdata !== bus_req_wdata ||
                             bmask !== bus_req_wmask || bwen !== bus_req_wen) begin
                    stable = 0;
                end
                bus_seen = 1;
                if (rq > 0) begin rq--; bus_req_ready = 1'b0; end
                else bus_req_ready = 1'b1;
            end
            if (bus_rsp_ready === 1'b1) begin
                if (rs > 0) begin rs--; bus_rsp_valid = 1'b0; end
                else begin bus_rsp_valid = 1'b1; bus_rsp_rdata = v.rdata; bus_rsp_err = v.err; end
            end
        end
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
    endtask

    task automatic run_check(input vec_t v, input string tag);
        int          lat;
        logic        err_o;
        logic [31:0] ld_o;
        bit          bus_seen;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [3:0]  bmask;
        logic        bwen;
        bit          stable;
        bit          busy_ok;
        bit          rr_ok;
        bit          legal;
        do_op(v, lat, err_o, ld_o, bus_seen, baddr, bwdata, bmask, bwen, stable, busy_ok, rr_ok);
        legal = (v.exp_lat != 1);
        chk({tag, " req_ready_at_issue"}, 32'(rr_ok), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, " mem_err"}, 32'(err_o), 32'(v.exp_err));
        chk({tag, " load_data"}, ld_o, v.exp_load);
        chk({tag, " bus_activity"}, 32'(bus_seen), 32'(legal));
        if (legal) begin
            chk({tag, " bus_addr"}, baddr, v.exp_baddr);
            chk({tag, " bus_wen"}, 32'(bwen), 32'(v.wen));
            chk({tag, " bus_wmask"}, 32'(bmask), 32'(v.exp_wmask));
            if (v.wen) chk({tag, " bus_wdata"}, bwdata, v.exp_bwdata);
            chk({tag, " fields_stable"}, 32'(stable), 32'd1);
            chk({tag, " req_ready_busy"}, 32'(busy_ok), 32'd1);
        end
    endtask

    initial begin
        vec_t v;
        tbl[0]  = '{1'b1, 3'b010, 32'h8000_0006, 32'h1122_3344, 32'h0, 1'b0, 0, 0, 1'b1, 1, 32'h0, 32'h0, 4'b0000, 32'h0};
        tbl[1]  = '{1'b1, 3'b000, 32'h8000_0003, 32'hAABB_CCDD, 32'h0, 1'b0, 0, 0, 1'b0, 3, 32'h8000_0000, 32'hDDDD_DDDD, 4'b1000, 32'h0};
        tbl[2]  = '{1'b0, 3'b000, 32'h8000_0001, 32'h0, 32'h0000_8000, 1'b0, 0, 0, 1'b0, 3, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_FF80};
        tbl[3]  = '{1'b0, 3'b100, 32'h8000_0001, 32'h0, 32'h0000_8000, 1'b0, 0, 0, 1'b0, 3, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_0080};
        tbl[4]  = '{1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h7FFF_1234, 1'b0, 2, 3, 1'b0, 8, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_7FFF};
        tbl[5]  = '{1'b0, 3'b010, 32'h8000_0000, 32'h0, 32'h1234_5678, 1'b1, 0, 0, 1'b1, 3, 32'h8000_0000, 32'h0, 4'b0000, 32'h0};
        tbl[6]  = '{1'b1, 3'b010, 32'h8000_0004, 32'hCAFE_BABE, 32'hDEAD_BEEF, 1'b0, 0, 0, 1'b0, 3, 32'h8000_0004, 32'hCAFE_BABE, 4'b1111, 32'h0};
        tbl[7]  = '{1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 1'b0, 1, 0, 1'b0, 4, 32'h8000_0000, 32'hBEEF_BEEF, 4'b1100, 32'h0};
        tbl[8]  = '{1'b0, 3'b101, 32'h8000_0001, 32'h0, 32'h0, 1'b0, 0, 0, 1'b1, 1, 32'h0, 32'h0, 4'b0000, 32'h0};
        tbl[9]  = '{1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 0, 0, 1'b1, 1, 32'h0, 32'h0, 4'b0000, 32'h0};
        tbl[10] = '{1'b1, 3'b100, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 0, 0, 1'b1, 1, 32'h0, 32'h0, 4'b0000, 32'h0};
        tbl[11] = '{1'b0, 3'b101, 32'h8000_0000, 32'h0, 32'hFFFF_8001, 1'b0, 0, 0, 1'b0, 3, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_8001};
        tbl[12] = '{1'b0, 3'b110, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 0, 0, 1'b1, 1, 32'h0, 32'h0, 4'b0000, 32'h0};
        tbl[13] = '{1'b0, 3'b001, 32'h8000_0000, 32'h0, 32'h1234_8001, 1'b0, 0, 1, 1'b0, 4, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_8001};
        tbl[14] = '{1'b1, 3'b000, 32'h8000_0000, 32'h0000_00A5, 32'h0, 1'b0, 0, 0, 1'b0, 3, 32'h8000_0000, 32'hA5A5_A5A5, 4'b0001, 32'hFFFF_8001};

        #1;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset bus_req_valid", 32'(bus_req_valid), 32'd0);
        chk("reset bus_rsp_ready", 32'(bus_rsp_ready), 32'd0);
        chk("reset mem_ready", 32'(mem_ready), 32'd0);
        chk("reset mem_err", 32'(mem_err), 32'd0);
        chk("reset bus_req_wen", 32'(bus_req_wen), 32'd0);
        chk("reset bus_req_addr", bus_req_addr, 32'd0);
        chk("reset bus_req_wdata", bus_req_wdata, 32'd0);
        chk("reset bus_req_wmask", 32'(bus_req_wmask), 32'd0);
        chk("reset load_data", load_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Ops are issued back to back: each starts in the previous op's mem_ready cycle
        for (int i = 0; i < 15; i++) begin
            run_check(tbl[i], $sformatf("vec%0d", i));
        end
        model_load = 32'hFFFF_8001;

        for (int i = 0; i < 40; i++) begin
            v.wen   = 1'($urandom_range(0, 1));
            v.f3    = 3'($urandom_range(0, 7));
            v.addr  = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.err   = ($urandom_range(0, 7) == 0);
            v.rqw   = $urandom_range(0, 2);
            v.rsw   = $urandom_range(0, 2);
            v = add_expect(v);
            run_check(v, $sformatf("rnd%0d", i));
        end

        // Reset while waiting for a load response
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0010;
        bus_req_ready = 1'b1; bus_rsp_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid in_rsp", 32'(bus_rsp_ready), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid bus_req_valid", 32'(bus_req_valid), 32'd0);
        chk("rst_mid bus_rsp_ready", 32'(bus_rsp_ready), 32'd0);
        chk("rst_mid mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_mid req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h5555_AAAA; bus_rsp_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stale_rsp mem_ready %0d", i), 32'(mem_ready), 32'd0);
            chk($sformatf("stale_rsp req_ready %0d", i), 32'(req_ready), 32'd1);
            chk($sformatf("stale_rsp load_data %0d", i), load_data, 32'd0);
        end
        bus_rsp_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
